adder_rf_datapath: RTL and testbench

- Datapath for the cumulative 1-to-10 adder processor; sits directly downstream of the control unit and executes its per-state control word each cycle.
- Contains an 8-entry register file with R0 hardwired to zero, a source mux (adder sum or constant), an adder, a loop-limit comparator and a registered output buffer.
- Returns the loop-condition flag iLe10 to the control unit.

---
 rtl/adder_rf_datapath_if.sv | 43 ++++
 rtl/adder_rf_datapath.sv | 88 ++++++++
 tb/tb_adder_rf_datapath.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/adder_rf_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_rf_datapath_if
// Description : Control-word / result bundle between the control unit and the
//               cumulative-adder datapath. ovfFlag exists only when
//               ADDER_DP_OVF_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_rf_datapath_if #(
    parameter int DATA_W = 8
) ();
    logic              RFSrcMuxSel;
    logic [2:0]        readAddr1;
    logic [2:0]        readAddr2;
    logic [2:0]        writeAddr;
    logic              writeEn;
    logic              outBuf;
    logic              iLe10;
    logic [DATA_W-1:0] outData;
    logic              outValid;
`ifdef ADDER_DP_OVF_FLAG_EN
    logic              ovfFlag;
`endif

    // Control unit side: issues the control word, observes results.
    modport master (
        output RFSrcMuxSel, readAddr1, readAddr2, writeAddr, writeEn, outBuf,
`ifdef ADDER_DP_OVF_FLAG_EN
        input  ovfFlag,
`endif
        input  iLe10, outData, outValid
    );

    // Datapath side: executes the control word.
    modport slave (
        input  RFSrcMuxSel, readAddr1, readAddr2, writeAddr, writeEn, outBuf,
`ifdef ADDER_DP_OVF_FLAG_EN
        output ovfFlag,
`endif
        output iLe10, outData, outValid
    );
endinterface
`default_nettype wire

// File: rtl/adder_rf_datapath.sv
`default_nettype none
// ============================================================================
// Module      : adder_rf_datapath
// Description : Datapath of the cumulative 1-to-10 adder: 8-entry register
//               file (R0 = 0), adder, source mux, loop-limit comparator and
//               registered output buffer. Optional sticky carry flag when
//               ADDER_DP_OVF_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_rf_datapath #(
    parameter int DATA_W     = 8,
    parameter int LIMIT      = 10,
    parameter int INIT_CONST = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    adder_rf_datapath_if.slave    dp
);
    localparam logic [DATA_W-1:0] c_limit = DATA_W'(LIMIT);
    localparam logic [DATA_W-1:0] c_init  = DATA_W'(INIT_CONST);

    // R0 has no storage; it is synthesised as a constant zero on read.
    logic [DATA_W-1:0] r_rf [1:7];
    logic [DATA_W-1:0] r_outdata;
    logic              r_outvalid;

    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_wdata;
    logic              w_wr;

    assign w_rdata1 = (dp.readAddr1 == 3'd0) ? '0 : r_rf[dp.readAddr1];
    assign w_rdata2 = (dp.readAddr2 == 3'd0) ? '0 : r_rf[dp.readAddr2];

`ifdef ADDER_DP_OVF_FLAG_EN
    logic [DATA_W:0]   w_sum_full;
    logic              r_ovf;

    assign w_sum_full = {1'b0, w_rdata1} + {1'b0, w_rdata2};
    assign w_sum      = w_sum_full[DATA_W-1:0];

    // Only sums that actually land in a real register count as overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_wr && dp.RFSrcMuxSel && w_sum_full[DATA_W]) begin
            r_ovf <= 1'b1;
        end
    end

    assign dp.ovfFlag = r_ovf;
`else
    assign w_sum = w_rdata1 + w_rdata2;
`endif

    assign w_wdata = dp.RFSrcMuxSel ? w_sum : c_init;
    assign w_wr    = dp.writeEn && (dp.writeAddr != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wr) begin
            r_rf[dp.writeAddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outdata  <= '0;
            r_outvalid <= 1'b0;
        end else begin
            r_outvalid <= dp.outBuf;
            if (dp.outBuf) begin
                r_outdata <= w_sum;
            end
        end
    end

    // Loop condition is taken from R1 storage, independent of read addresses.
    assign dp.iLe10    = (r_rf[1] <= c_limit);
    assign dp.outData  = r_outdata;
    assign dp.outValid = r_outvalid;

endmodule
`default_nettype wire

// File: tb/tb_adder_rf_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_rf_datapath
// Description : Directed self-checking bench for adder_rf_datapath, with
//               extra checks when ADDER_DP_OVF_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_rf_datapath;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    int   m_r1;
    int   m_r2;

    adder_rf_datapath_if #(.DATA_W(8)) bus ();

    adder_rf_datapath #(
        .DATA_W    (8),
        .LIMIT     (10),
        .INIT_CONST(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dp (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one control word for one clock; returns 1ns after the edge.
    task automatic cw(input logic sel, input logic [2:0] ra1, input logic [2:0] ra2,
                      input logic [2:0] wa, input logic we, input logic ob);
        bus.RFSrcMuxSel = sel;
        bus.readAddr1   = ra1;
        bus.readAddr2   = ra2;
        bus.writeAddr   = wa;
        bus.writeEn     = we;
        bus.outBuf      = ob;
        @(posedge clk);
        #1;
        bus.writeEn = 1'b0;
        bus.outBuf  = 1'b0;
    endtask

    // Build an arbitrary value in a register by shift-and-add from constant 1.
    task automatic set_reg(input logic [2:0] addr, input logic [7:0] val);
        logic [2:0] s;
        s = (addr == 3'd7) ? 3'd6 : 3'd7;
        cw(1'b1, 3'd0, 3'd0, addr, 1'b1, 1'b0);
        cw(1'b0, 3'd0, 3'd0, s, 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            cw(1'b1, addr, addr, addr, 1'b1, 1'b0);
            if (val[i]) cw(1'b1, addr, s, addr, 1'b1, 1'b0);
        end
    endtask

    task automatic read_reg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        cw(1'b0, addr, 3'd0, 3'd0, 1'b0, 1'b1);
        check(tag, bus.outData, exp);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        bus.writeEn = 1'b0;
        bus.outBuf  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference control sequence; stops on !iLe10 or after max_iter iterations.
    task automatic run_loop(input int max_iter, output int iters);
        logic [7:0] exp;
        iters = 0;
        m_r1  = 0;
        m_r2  = 0;
        cw(1'b1, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0);
        cw(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0);
        cw(1'b0, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0);
        while (bus.iLe10 && iters < max_iter) begin
            check("loop_ile10", bus.iLe10, (m_r1 <= 10) ? 1 : 0);
            exp = 8'(m_r1 + m_r2);
            cw(1'b1, 3'd1, 3'd2, 3'd2, 1'b1, 1'b1);
            check("loop_outvalid", bus.outValid, 1);
            check("loop_outdata", bus.outData, exp);
            m_r2 = exp;
            cw(1'b1, 3'd1, 3'd3, 3'd1, 1'b1, 1'b0);
            check("loop_pulse_end", bus.outValid, 0);
            m_r1++;
            iters++;
        end
    endtask

    initial begin
        int iters;
        n_checks = 0;
        n_fails  = 0;
        bus.RFSrcMuxSel = 1'b0;
        bus.readAddr1   = 3'd0;
        bus.readAddr2   = 3'd0;
        bus.writeAddr   = 3'd0;
        bus.writeEn     = 1'b0;
        bus.outBuf      = 1'b0;

        do_reset(2);
        check("rst_outdata", bus.outData, 0);
        check("rst_outvalid", bus.outValid, 0);
        check("rst_ile10", bus.iLe10, 1);
`ifdef ADDER_DP_OVF_FLAG_EN
        check("rst_ovf", bus.ovfFlag, 0);
`endif

        // Full reference sequence: 11 pulses ending at 55.
        run_loop(20, iters);
        check("ref_pulses", iters, 11);
        check("ref_ile10_done", bus.iLe10, 0);
        check("ref_hold55", bus.outData, 55);
        read_reg("ref_r1", 3'd1, 11);
`ifdef ADDER_DP_OVF_FLAG_EN
        check("ref_ovf", bus.ovfFlag, 0);
`endif

        // Writes to R0 are ignored.
        set_reg(3'd6, 8'h5A);
        cw(1'b1, 3'd6, 3'd0, 3'd0, 1'b1, 1'b0);
        read_reg("r0_after_write", 3'd0, 0);
        read_reg("r6_loaded", 3'd6, 8'h5A);

        // Same-cycle write/read of R4: sum uses old R4 (0) + R6 (7).
        set_reg(3'd6, 8'd7);
        cw(1'b1, 3'd4, 3'd6, 3'd4, 1'b1, 1'b1);
        check("rw_same_old", bus.outData, 7);
        check("rw_same_valid", bus.outValid, 1);
        read_reg("rw_next_new", 3'd4, 7);

        // Comparator boundaries.
        set_reg(3'd1, 8'd10);
        check("ile10_r1_10", bus.iLe10, 1);
        set_reg(3'd1, 8'd11);
        check("ile10_r1_11", bus.iLe10, 0);
        set_reg(3'd1, 8'd255);
        check("ile10_r1_255", bus.iLe10, 0);
        set_reg(3'd1, 8'd0);
        check("ile10_r1_0", bus.iLe10, 1);

        // Truncating add: 200 + 100 = 300 -> 44.
        set_reg(3'd1, 8'd200);
        set_reg(3'd2, 8'd100);
`ifdef ADDER_DP_OVF_FLAG_EN
        check("ovf_before", bus.ovfFlag, 0);
`endif
        cw(1'b1, 3'd1, 3'd2, 3'd5, 1'b1, 1'b1);
        check("trunc_outdata", bus.outData, 44);
        read_reg("trunc_r5", 3'd5, 44);
`ifdef ADDER_DP_OVF_FLAG_EN
        check("ovf_set", bus.ovfFlag, 1);
        cw(1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0);
        check("ovf_sticky", bus.ovfFlag, 1);
`endif

        // Reset mid-loop with writeEn/outBuf asserted: reset wins.
        do_reset(1);
        run_loop(5, iters);
        check("mid_iters", iters, 5);
        check("mid_outdata_pre", bus.outData, 10);
        rst = 1'b1;
        cw(1'b1, 3'd1, 3'd2, 3'd1, 1'b1, 1'b1);
        rst = 1'b0;
        check("mid_rst_outdata", bus.outData, 0);
        check("mid_rst_outvalid", bus.outValid, 0);
        check("mid_rst_ile10", bus.iLe10, 1);
`ifdef ADDER_DP_OVF_FLAG_EN
        check("mid_rst_ovf", bus.ovfFlag, 0);
`endif
        for (int r = 1; r < 8; r++) begin
            read_reg($sformatf("mid_rst_r%0d", r), 3'(r), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
